mv_ref_fetch_gen: RTL and testbench

- Reader-side consumer of the stored motion vector 0 (signed 8-bit; [7:4] horizontal, [3:0] vertical, each a signed quarter-pel value).
- Accepts one MV per block over a valid/ready handshake and splits each component into integer and fractional (quarter-pel) parts.
- Scans the reference-pixel window the interpolation filter needs, one (x, y) fetch address per accepted beat, clamped to frame edges.
- Sits between the MV registers and the reference-frame memory / interpolation filter datapath.

---
 rtl/mv_pkg.sv | 24 ++
 rtl/mv_comp_decode.sv | 26 ++
 rtl/mv_ref_fetch_gen.sv | 180 ++++++++++++++++++
 tb/tb_mv_ref_fetch_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
// Shared motion-vector definitions: field widths, MV component slicing and
// the fetch-generator state encoding.
package mv_pkg;

  localparam int MV_W      = 8;
  localparam int MV_COMP_W = 4;
  localparam int FRAC_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic [MV_COMP_W-1:0] mv_horiz(input logic [MV_W-1:0] mv);
    return mv[MV_W-1 -: MV_COMP_W];
  endfunction

  function automatic logic [MV_COMP_W-1:0] mv_vert(input logic [MV_W-1:0] mv);
    return mv[MV_COMP_W-1:0];
  endfunction

endpackage

// File: rtl/mv_comp_decode.sv
// Splits one signed quarter-pel MV component into integer/fractional parts
// plus the filter pre-roll and window extension it implies.
module mv_comp_decode
  import mv_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int EXT_W = $clog2(TAPS)
) (
  input  logic [MV_COMP_W-1:0] comp_i,
  output logic [MV_COMP_W-1:0] int_o,
  output logic [FRAC_W-1:0]    frac_o,
  output logic [EXT_W-1:0]     pre_o,
  output logic [EXT_W-1:0]     ext_o
);

  logic has_frac;

  assign int_o    = $signed(comp_i) >>> FRAC_W;
  assign frac_o   = comp_i[FRAC_W-1:0];
  assign has_frac = |frac_o;

  // A fractional phase needs TAPS-1 extra pixels, TAPS/2-1 of them before the block.
  assign ext_o = has_frac ? EXT_W'(TAPS - 1)     : '0;
  assign pre_o = has_frac ? EXT_W'(TAPS / 2 - 1) : '0;

endmodule

// File: rtl/mv_ref_fetch_gen.sv
// Reference-window fetch address generator: captures one MV per block and
// scans the interpolation window in raster order, clamped to the frame.
//
// state | meaning
// IDLE  | waiting for an MV, MV_READY high
// LOAD  | decode captured MV, latch window origin/size and phases
// SCAN  | present one clamped (x, y) per accepted beat
// FIN   | DONE pulse, then back to IDLE
module mv_ref_fetch_gen
  import mv_pkg::*;
#(
  parameter int BLK_W   = 8,
  parameter int BLK_H   = 8,
  parameter int TAPS    = 8,
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int COORD_W = 7
) (
  input  logic               CLK,
  input  logic               RST_SYNC,
  input  logic [MV_W-1:0]    MV_IN,
  input  logic [COORD_W-1:0] BLK_X,
  input  logic [COORD_W-1:0] BLK_Y,
  input  logic               MV_VALID,
  output logic               MV_READY,
  output logic [FRAC_W-1:0]  FRAC_X,
  output logic [FRAC_W-1:0]  FRAC_Y,
  output logic [COORD_W-1:0] ADDR_X,
  output logic [COORD_W-1:0] ADDR_Y,
  output logic               ADDR_VALID,
  input  logic               ADDR_READY,
  output logic               DONE
);

  localparam int EXT_W   = $clog2(TAPS);
  localparam int SW      = COORD_W + 2;
  localparam int CNT_X_W = $clog2(BLK_W + TAPS);
  localparam int CNT_Y_W = $clog2(BLK_H + TAPS);

  localparam logic signed [SW-1:0] X_MAX = SW'(FRAME_W - 1);
  localparam logic signed [SW-1:0] Y_MAX = SW'(FRAME_H - 1);

  state_e                     state_q;
  logic [MV_W-1:0]            mv_q;
  logic [COORD_W-1:0]         blk_x_q, blk_y_q;
  logic [FRAC_W-1:0]          frac_x_q, frac_y_q;
  logic signed [SW-1:0]       start_x_q, start_y_q;
  logic [CNT_X_W-1:0]         last_col_q, col_q;
  logic [CNT_Y_W-1:0]         last_row_q, row_q;
  logic                       mv_ready_q, addr_valid_q, done_q;

  logic [MV_COMP_W-1:0]       comp_x, comp_y, int_x, int_y;
  logic [FRAC_W-1:0]          frac_x, frac_y;
  logic [EXT_W-1:0]           pre_x, pre_y, ext_x, ext_y;
  logic signed [SW-1:0]       start_x_d, start_y_d;
  logic [CNT_X_W-1:0]         last_col_d;
  logic [CNT_Y_W-1:0]         last_row_d;
  logic signed [SW-1:0]       raw_x, raw_y;
  logic                       beat_acc;

  assign comp_x = mv_horiz(mv_q);
  assign comp_y = mv_vert(mv_q);

  mv_comp_decode #(.TAPS(TAPS), .EXT_W(EXT_W)) u_dec_x (
    .comp_i (comp_x),
    .int_o  (int_x),
    .frac_o (frac_x),
    .pre_o  (pre_x),
    .ext_o  (ext_x)
  );

  mv_comp_decode #(.TAPS(TAPS), .EXT_W(EXT_W)) u_dec_y (
    .comp_i (comp_y),
    .int_o  (int_y),
    .frac_o (frac_y),
    .pre_o  (pre_y),
    .ext_o  (ext_y)
  );

  // Window origin may go negative or past the frame; clamping happens per beat.
  assign start_x_d = $signed(SW'(blk_x_q)) + SW'($signed(int_x)) - $signed(SW'(pre_x));
  assign start_y_d = $signed(SW'(blk_y_q)) + SW'($signed(int_y)) - $signed(SW'(pre_y));

  assign last_col_d = CNT_X_W'(BLK_W - 1) + CNT_X_W'(ext_x);
  assign last_row_d = CNT_Y_W'(BLK_H - 1) + CNT_Y_W'(ext_y);

  assign raw_x = start_x_q + $signed(SW'(col_q));
  assign raw_y = start_y_q + $signed(SW'(row_q));

  function automatic logic [COORD_W-1:0] clamp(input logic signed [SW-1:0] raw,
                                               input logic signed [SW-1:0] lim);
    if (raw[SW-1]) begin
      return '0;
    end else if (raw > lim) begin
      return lim[COORD_W-1:0];
    end
    return raw[COORD_W-1:0];
  endfunction

  assign beat_acc = addr_valid_q && ADDR_READY;

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state_q      <= ST_IDLE;
      mv_q         <= '0;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      frac_x_q     <= '0;
      frac_y_q     <= '0;
      start_x_q    <= '0;
      start_y_q    <= '0;
      last_col_q   <= '0;
      last_row_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      mv_ready_q   <= 1'b0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MV_VALID && mv_ready_q) begin
            mv_q       <= MV_IN;
            blk_x_q    <= BLK_X;
            blk_y_q    <= BLK_Y;
            mv_ready_q <= 1'b0;
            state_q    <= ST_LOAD;
          end else begin
            mv_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          frac_x_q     <= frac_x;
          frac_y_q     <= frac_y;
          start_x_q    <= start_x_d;
          start_y_q    <= start_y_d;
          last_col_q   <= last_col_d;
          last_row_q   <= last_row_d;
          col_q        <= '0;
          row_q        <= '0;
          addr_valid_q <= 1'b1;
          state_q      <= ST_SCAN;
        end
        ST_SCAN: begin
          if (beat_acc) begin
            if (col_q == last_col_q) begin
              col_q <= '0;
              if (row_q == last_row_q) begin
                addr_valid_q <= 1'b0;
                done_q       <= 1'b1;
                state_q      <= ST_FIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_FIN: begin
          done_q     <= 1'b0;
          mv_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MV_READY   = mv_ready_q;
  assign FRAC_X     = frac_x_q;
  assign FRAC_Y     = frac_y_q;
  assign ADDR_X     = clamp(raw_x, X_MAX);
  assign ADDR_Y     = clamp(raw_y, Y_MAX);
  assign ADDR_VALID = addr_valid_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_mv_ref_fetch_gen.sv
// Bench for mv_ref_fetch_gen: directed cases plus random blocks, each checked
// against an arithmetic model of the clamped reference window.
module tb_mv_ref_fetch_gen;

  localparam int BLK_W   = 8;
  localparam int BLK_H   = 8;
  localparam int TAPS    = 8;
  localparam int FRAME_W = 64;
  localparam int FRAME_H = 64;
  localparam int COORD_W = 7;

  logic               clk;
  logic               RST_SYNC;
  logic [7:0]         MV_IN;
  logic [COORD_W-1:0] BLK_X, BLK_Y;
  logic               MV_VALID, MV_READY;
  logic [1:0]         FRAC_X, FRAC_Y;
  logic [COORD_W-1:0] ADDR_X, ADDR_Y;
  logic               ADDR_VALID, ADDR_READY, DONE;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_x[$];
  int exp_y[$];
  int exp_fx, exp_fy;

  mv_ref_fetch_gen #(
    .BLK_W(BLK_W), .BLK_H(BLK_H), .TAPS(TAPS),
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .COORD_W(COORD_W)
  ) dut (
    .CLK        (clk),
    .RST_SYNC   (RST_SYNC),
    .MV_IN      (MV_IN),
    .BLK_X      (BLK_X),
    .BLK_Y      (BLK_Y),
    .MV_VALID   (MV_VALID),
    .MV_READY   (MV_READY),
    .FRAC_X     (FRAC_X),
    .FRAC_Y     (FRAC_Y),
    .ADDR_X     (ADDR_X),
    .ADDR_Y     (ADDR_Y),
    .ADDR_VALID (ADDR_VALID),
    .ADDR_READY (ADDR_READY),
    .DONE       (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  // Component c = 4*INT + FRAC with FRAC in 0..3.
  task automatic build_expect(input logic [7:0] mv, input int bx, input int by);
    int h, v, fh, fv, ih, iv, sx, sy, w, hg;
    h  = int'($signed(mv[7:4]));
    v  = int'($signed(mv[3:0]));
    fh = h & 3;
    fv = v & 3;
    ih = (h - fh) / 4;
    iv = (v - fv) / 4;
    sx = bx + ih - ((fh != 0) ? TAPS / 2 - 1 : 0);
    sy = by + iv - ((fv != 0) ? TAPS / 2 - 1 : 0);
    w  = BLK_W + ((fh != 0) ? TAPS - 1 : 0);
    hg = BLK_H + ((fv != 0) ? TAPS - 1 : 0);
    exp_x.delete();
    exp_y.delete();
    for (int r = 0; r < hg; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_x.push_back(clip(sx + c, FRAME_W - 1));
        exp_y.push_back(clip(sy + r, FRAME_H - 1));
      end
    end
    exp_fx = fh;
    exp_fy = fv;
  endtask

  // bp_mode: 0 always ready, 1 three-cycle stall at beat index 9, 2 random ready.
  task automatic run_block(input logic [7:0] mv, input int bx, input int by,
                           input int bp_mode, input int rst_at, input bit inject);
    int  b, cyc, total, stalls, budget;
    bit  rdy, inj_done, inj_live;
    build_expect(mv, bx, by);
    total    = exp_x.size();
    budget   = total * 8 + 50;
    stalls   = 0;
    inj_done = 0;
    inj_live = 0;

    @(negedge clk);
    chk("idle_ready", MV_READY, 1);
    MV_IN    = mv;
    BLK_X    = COORD_W'(bx);
    BLK_Y    = COORD_W'(by);
    MV_VALID = 1'b1;
    ADDR_READY = 1'b0;
    @(negedge clk);
    MV_VALID = 1'b0;
    chk("load_valid_low", ADDR_VALID, 0);
    chk("load_ready_low", MV_READY, 0);
    @(negedge clk);
    chk("first_valid", ADDR_VALID, 1);
    chk("frac_x", FRAC_X, exp_fx);
    chk("frac_y", FRAC_Y, exp_fy);

    b   = 0;
    cyc = 0;
    while (b < total && cyc < budget) begin
      chk("scan_valid", ADDR_VALID, 1);
      chk("done_early", DONE, 0);
      chk("addr", {ADDR_X, ADDR_Y}, (exp_x[b] << COORD_W) | exp_y[b]);
      if (inj_live) begin
        MV_VALID = 1'b0;
        MV_IN    = mv;
        BLK_X    = COORD_W'(bx);
        inj_live = 0;
      end
      if (inject && !inj_done && b == 5) begin
        chk("busy_ready", MV_READY, 0);
        MV_IN    = 8'h12;
        BLK_X    = 7'd3;
        MV_VALID = 1'b1;
        inj_done = 1;
        inj_live = 1;
      end
      case (bp_mode)
        1:       rdy = !(b == 9 && stalls < 3);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stalls++;
      if (rst_at >= 0 && b == rst_at) begin
        RST_SYNC   = 1'b1;
        ADDR_READY = 1'b1;
        @(negedge clk);
        RST_SYNC = 1'b0;
        chk("rst_valid", ADDR_VALID, 0);
        chk("rst_done", DONE, 0);
        chk("rst_frac_x", FRAC_X, 0);
        chk("rst_frac_y", FRAC_Y, 0);
        chk("rst_addr", {ADDR_X, ADDR_Y}, 0);
        @(negedge clk);
        chk("rst_ready_after", MV_READY, 1);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", DONE, 0);
          chk("rst_no_valid", ADDR_VALID, 0);
        end
        return;
      end
      ADDR_READY = rdy;
      if (rdy) b++;
      cyc++;
      @(negedge clk);
    end
    chk("beats_complete", b, total);
    chk("end_valid_low", ADDR_VALID, 0);
    chk("done_pulse", DONE, 1);
    chk("fin_ready_low", MV_READY, 0);
    @(negedge clk);
    chk("done_cleared", DONE, 0);
    chk("idle_after_fin", MV_READY, 1);
    chk("frac_x_hold", FRAC_X, exp_fx);
    chk("frac_y_hold", FRAC_Y, exp_fy);
    ADDR_READY = 1'b0;
  endtask

  initial begin
    RST_SYNC   = 1'b1;
    MV_VALID   = 1'b0;
    MV_IN      = '0;
    BLK_X      = '0;
    BLK_Y      = '0;
    ADDR_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mv_ready", MV_READY, 0);
    chk("rst_addr_valid", ADDR_VALID, 0);
    chk("rst_done0", DONE, 0);
    chk("rst_frac", {FRAC_X, FRAC_Y}, 0);
    chk("rst_addr0", {ADDR_X, ADDR_Y}, 0);
    RST_SYNC = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", MV_READY, 1);

    run_block(8'h00, 0, 0, 0, -1, 0);
    run_block(8'h61, 16, 16, 0, -1, 0);
    run_block(8'hF0, 0, 0, 0, -1, 0);
    run_block(8'h00, 0, 0, 1, -1, 0);
    run_block(8'h00, 0, 0, 0, -1, 1);
    run_block(8'h12, 8, 8, 0, -1, 0);
    run_block(8'h61, 16, 16, 0, 19, 0);
    run_block(8'h00, 0, 0, 0, -1, 0);
    run_block(8'h33, 60, 60, 2, -1, 0);

    for (int i = 0; i < 10; i++) begin
      run_block(8'($urandom_range(0, 255)), int'($urandom_range(0, 70)),
                int'($urandom_range(0, 70)), 2, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
